// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch block.
package instruction_fetch_pkg;

  localparam int          INSTR_WIDTH      = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]            pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_buffer.sv
// Synchronous FIFO of {pc, instr} pairs: wrap-around pointers plus an occupancy counter.
module fetch_buffer
  import instruction_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: head is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// PC owner and instruction buffer feeding decode; FETCH_MISALIGN_TRAP_EN adds the
// fetch_fault output and the HALT trap on a misaligned redirect.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [31:0]            imem_req_addr,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [31:0]            instr_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic                   fetch_fault,
`endif
  output fetch_state_t           dbg_state
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
  // valid never waits on ready. Responses have no ready and arrive in request order.

  fetch_state_t state;
  logic [31:0]  pc, rsp_pc, redirect_target;
  logic [CW-1:0] outstanding, drop_cnt, drop_next, stale_cnt, buf_count;
  fetch_entry_t head, last_entry, push_entry, out_entry;
  logic active, redirect_take, halt_now, accept, push, pop, flush;

  assign active          = (state == RUN) || (state == DRAIN);
  assign redirect_take   = redirect_valid && (state != HALT);
  assign stale_cnt       = outstanding - CW'(imem_rsp_valid);

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redirect_target = redirect_pc;
  assign halt_now        = redirect_take && (redirect_pc[1:0] != 2'b00);
`else
  assign redirect_target = redirect_pc & ~32'h3;
  assign halt_now        = 1'b0;
`endif

  // Credit rule: buffered plus in-flight words never exceed the buffer depth.
  assign imem_req_valid = active && !redirect_valid &&
                          ((CW+1)'(outstanding) + (CW+1)'(buf_count) < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign push       = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid && (state != HALT);
  assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};
  assign flush      = redirect_valid || (state == HALT);

  assign instr_valid = (buf_count != '0) && !redirect_valid;
  assign pop         = instr_valid && instr_ready;
  assign out_entry   = (buf_count != '0) ? head : last_entry;
  assign instr       = out_entry.instr;
  assign instr_pc    = out_entry.pc;
  assign dbg_state   = state;

  always_comb begin
    drop_next = drop_cnt;
    if (redirect_take) drop_next = stale_cnt;
    else if (imem_rsp_valid && (drop_cnt != '0)) drop_next = drop_cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      last_entry  <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fetch_fault <= 1'b0;
`endif
    end else begin
      outstanding <= outstanding + CW'(accept) - CW'(imem_rsp_valid);
      drop_cnt    <= drop_next;
      if (pop) last_entry <= head;
      if (redirect_take) begin
        pc     <= redirect_target;
        rsp_pc <= redirect_target;
      end else begin
        if (accept) pc     <= pc + PC_STEP;
        if (push)   rsp_pc <= rsp_pc + PC_STEP;
      end
      if (halt_now) begin
        state <= HALT;
`ifdef FETCH_MISALIGN_TRAP_EN
        fetch_fault <= 1'b1;
`endif
      end else begin
        case (state)
          BOOT:       state <= RUN;
          RUN, DRAIN: state <= (drop_next != '0) ? DRAIN : RUN;
          default:    state <= HALT;
        endcase
      end
    end
  end

  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .count      (buf_count),
    .head       (head)
  );

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Producer side of the `instr` interface that feeds instruction decode.
- Owns the PC and issues word fetches to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers fetched words with their PCs and presents them to decode through a valid/ready handshake.
- Accepts a redirect from branch/jump resolution, which flushes buffered and in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 2, buffer entries; also the maximum number of outstanding requests (credit limit), power of two ≥2

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word address of request (current PC)
imem_rsp_valid  in  1  response valid; no backpressure, in-order, ≥1 cycle after accept
imem_rsp_data  in  32  fetched instruction word
redirect_valid  in  1  one-cycle PC redirect pulse
redirect_pc  in  32  redirect target
instr_valid  out  1  buffered instruction available to decode
instr_ready  in  1  decode consumes instruction
instr  out  32  instruction word to decode
instr_pc  out  32  PC of `instr`

Behaviour:
- Reset (reset=0, async): state=BOOT, pc=RESET_PC, rsp_pc=RESET_PC, outstanding=0, drop_cnt=0, buffer empty. Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- Reset asserted mid-operation discards everything. Responses to pre-reset requests that arrive after reset are the memory's responsibility and must not occur.
- State machine:
  - BOOT -> RUN unconditionally, one cycle after reset release. No request in BOOT.
  - RUN -> DRAIN on redirect when stale responses remain, i.e. outstanding minus (imem_rsp_valid this cycle) > 0.
  - DRAIN -> RUN when drop_cnt reaches 0.
  - A redirect in DRAIN reloads drop_cnt with the same formula.
- Request: imem_req_valid=1 in RUN and DRAIN when (outstanding + buffer_count) < DEPTH and redirect_valid=0.
  - Accept (valid & ready): pc += 4; outstanding++.
  - imem_req_addr=pc combinationally.
- Response: outstanding-- on every imem_rsp_valid.
  - If drop_cnt>0: data discarded, drop_cnt--.
  - Otherwise: push {rsp_pc, data}; rsp_pc += 4.
  - Buffer cannot overflow, guaranteed by the credit rule.
  - Simultaneous accept and response: outstanding unchanged.
- Redirect (redirect_valid=1), applied at that clock edge:
  - pc and rsp_pc <= redirect_pc.
  - Buffer flushed.
  - drop_cnt <= outstanding - imem_rsp_valid. A response arriving in the redirect cycle is discarded.
  - No request issued.
  - instr_valid forced 0 in the redirect cycle.
  - Redirect overrides a same-cycle consume and push.
- Decode side:
  - instr_valid = buffer non-empty and redirect_valid=0.
  - instr and instr_pc come from the buffer head; hold the last popped value when empty (0 after reset).
  - Pop on instr_valid & instr_ready.
  - Push and pop in the same cycle on a full buffer are legal.
- Latency: response in cycle N appears on instr_valid in cycle N+1 (registered buffer, no bypass).
- Address arithmetic is modulo 2^32; PC 32'hFFFF_FFFC wraps to 0.

Optional Feature:
- Macro FETCH_MISALIGN_TRAP_EN.
- Defined: adds output fetch_fault (1 bit, reset 0) and state HALT.
  - Redirect with redirect_pc[1:0]!=0 enters HALT and sets fetch_fault=1.
  - In HALT: no requests, buffer flushed, outstanding responses discarded, instr_valid=0.
  - Exit only by reset.
- Undefined: redirect_pc[1:0] ignored (treated as 2'b00); no fetch_fault port, no HALT state.

Decomposition:
- Shared package additions:
  - fetch_state_t enum (BOOT, RUN, DRAIN, HALT).
  - INSTR_WIDTH=32.
  - PC_STEP=4.
  - Default RESET_PC constant.
- One sub-module, fetch_buffer:
  - Synchronous FIFO of {pc, instr}, DEPTH entries.
  - Ports: push, pop, flush, count, head.
  - Wrap-around pointers plus an occupancy counter.

Test Plan:
- Reset release, imem_req_ready=1, memory responds 1 cycle later: requests to 0x0, 0x4 (BOOT cycle idle); decode sees instr_pc 0x0 then 0x4 with matching data.
- instr_ready=0 for 10 cycles, DEPTH=2: at most 2 requests accepted, buffer full, imem_req_valid=0; releasing instr_ready drains in order with no loss.
- 2 requests outstanding, redirect to 0x100: both responses discarded (state DRAIN); next delivered instr_pc=0x100.
- Redirect in the same cycle as a response with 1 outstanding: response dropped, drop_cnt=0, state stays RUN, first delivered instr_pc=redirect target.
- reset pulled low mid-stream with a full buffer: instr_valid=0 and imem_req_valid=0 immediately; after release, fetching restarts at RESET_PC.
- With FETCH_MISALIGN_TRAP_EN, redirect to 0x102: fetch_fault=1, no further requests, instr_valid=0 until reset.
